rca_result_accumulator: RTL and testbench

RCA_RESULT_ACCUMULATOR -- requirements
Module: rca_result_accumulator

---
 rtl/rca_acc_pkg.sv | 14 +
 rtl/rca_result_accumulator.sv | 99 +++++++++
 tb/tb_rca_result_accumulator.sv | 197 +++++++++++++++++++
 3 files changed

// File: rtl/rca_acc_pkg.sv
// Shared types and default sizes for the adder-result accumulator.
package rca_acc_pkg;

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        ACCUM = 2'd1,
        DONE  = 2'd2
    } rca_state_e;

    localparam int DEF_WIDTH     = 8;
    localparam int DEF_ACC_WIDTH = 16;
    localparam int DEF_CNT_W     = 4;

endpackage

// File: rtl/rca_result_accumulator.sv
// Sums a run of ripple-carry adder results {carry,sum} into a wide
// accumulator with sticky wrap detection and a valid/ready result port.
module rca_result_accumulator
    import rca_acc_pkg::*;
#(
    parameter int WIDTH     = DEF_WIDTH,
    parameter int ACC_WIDTH = DEF_ACC_WIDTH,
    parameter int CNT_W     = DEF_CNT_W
) (
    input  logic                 clk,
    input  logic                 rst,
    input  logic                 start,
    input  logic [CNT_W-1:0]     num_samples,
    input  logic                 in_valid,
    output logic                 in_ready,
    input  logic [WIDTH-1:0]     in_sum,
    input  logic                 in_carry,
    output logic                 out_valid,
    input  logic                 out_ready,
    output logic [ACC_WIDTH-1:0] out_acc,
    output logic                 out_overflow,
    output logic [CNT_W-1:0]     out_count,
    output logic                 busy
);

    rca_state_e           state_q, state_d;
    logic [ACC_WIDTH-1:0] acc_q, acc_d;
    logic [CNT_W-1:0]     cnt_q, cnt_d;
    logic [CNT_W-1:0]     num_q, num_d;
    logic                 ovf_q, ovf_d;

    logic [ACC_WIDTH:0]   beat_ext;
    logic [ACC_WIDTH:0]   sum_ext;
    logic [CNT_W-1:0]     cnt_inc;

    // One extra bit on the add exposes the wrap out of the accumulator.
    assign beat_ext = {{(ACC_WIDTH-WIDTH){1'b0}}, in_carry, in_sum};
    assign sum_ext  = {1'b0, acc_q} + beat_ext;
    assign cnt_inc  = cnt_q + CNT_W'(1);

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q <= IDLE;
            acc_q   <= '0;
            cnt_q   <= '0;
            num_q   <= '0;
            ovf_q   <= 1'b0;
        end else begin
            state_q <= state_d;
            acc_q   <= acc_d;
            cnt_q   <= cnt_d;
            num_q   <= num_d;
            ovf_q   <= ovf_d;
        end
    end

    always_comb begin
        state_d = state_q;
        acc_d   = acc_q;
        cnt_d   = cnt_q;
        num_d   = num_q;
        ovf_d   = ovf_q;
        unique case (state_q)
            IDLE: begin
                if (start) begin
                    acc_d   = '0;
                    cnt_d   = '0;
                    ovf_d   = 1'b0;
                    num_d   = num_samples;
                    state_d = (num_samples == '0) ? DONE : ACCUM;
                end
            end
            ACCUM: begin
                if (in_valid) begin
                    acc_d = sum_ext[ACC_WIDTH-1:0];
                    ovf_d = ovf_q | sum_ext[ACC_WIDTH];
                    cnt_d = cnt_inc;
                    if (cnt_inc == num_q) begin
                        state_d = DONE;
                    end
                end
            end
            DONE: begin
                if (out_ready) begin
                    state_d = IDLE;
                end
            end
            default: state_d = IDLE;
        endcase
    end

    assign in_ready     = (state_q == ACCUM);
    assign out_valid    = (state_q == DONE);
    assign busy         = (state_q != IDLE);
    assign out_acc      = acc_q;
    assign out_overflow = ovf_q;
    assign out_count    = cnt_q;

endmodule

// File: tb/tb_rca_result_accumulator.sv
// Directed bench for the accumulator; a 10-bit-accumulator copy shares
// the stimulus so the wrap case can be observed.
module tb_rca_result_accumulator;

    logic        clk = 1'b0;
    logic        rst;
    logic        start;
    logic [3:0]  num_samples;
    logic        in_valid;
    logic        in_ready;
    logic [7:0]  in_sum;
    logic        in_carry;
    logic        out_valid;
    logic        out_ready;
    logic [15:0] out_acc;
    logic        out_overflow;
    logic [3:0]  out_count;
    logic        busy;

    logic        in_ready10;
    logic        out_valid10;
    logic [9:0]  out_acc10;
    logic        out_overflow10;
    logic [3:0]  out_count10;
    logic        busy10;

    int total = 0;
    int bad   = 0;

    always #5 clk = ~clk;

    rca_result_accumulator #(.WIDTH(8), .ACC_WIDTH(16), .CNT_W(4)) u_dut (
        .clk(clk), .rst(rst), .start(start), .num_samples(num_samples),
        .in_valid(in_valid), .in_ready(in_ready), .in_sum(in_sum),
        .in_carry(in_carry), .out_valid(out_valid), .out_ready(out_ready),
        .out_acc(out_acc), .out_overflow(out_overflow),
        .out_count(out_count), .busy(busy)
    );

    rca_result_accumulator #(.WIDTH(8), .ACC_WIDTH(10), .CNT_W(4)) u_dut10 (
        .clk(clk), .rst(rst), .start(start), .num_samples(num_samples),
        .in_valid(in_valid), .in_ready(in_ready10), .in_sum(in_sum),
        .in_carry(in_carry), .out_valid(out_valid10), .out_ready(out_ready),
        .out_acc(out_acc10), .out_overflow(out_overflow10),
        .out_count(out_count10), .busy(busy10)
    );

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic chk(input string tag, input logic [31:0] obs,
                       input logic [31:0] exp);
        total++;
        assert (obs === exp) else begin
            bad++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    initial begin
        rst = 1'b1; start = 1'b0; num_samples = '0; in_valid = 1'b0;
        in_sum = '0; in_carry = 1'b0; out_ready = 1'b0;
        step(); step();
        rst = 1'b0;
        chk("rst_acc", 32'(out_acc), 32'h0);
        chk("rst_cnt", 32'(out_count), 32'h0);
        chk("rst_ovf", 32'(out_overflow), 32'h0);
        chk("rst_in_ready", 32'(in_ready), 32'h0);
        chk("rst_out_valid", 32'(out_valid), 32'h0);
        chk("rst_busy", 32'(busy), 32'h0);

        // three back-to-back beats
        start = 1'b1; num_samples = 4'd3;
        step();
        start = 1'b0;
        chk("run3_in_ready", 32'(in_ready), 32'h1);
        chk("run3_busy", 32'(busy), 32'h1);
        in_valid = 1'b1; in_carry = 1'b0; in_sum = 8'h10;
        step();
        in_carry = 1'b1; in_sum = 8'h05;
        step();
        chk("run3_no_early_valid", 32'(out_valid), 32'h0);
        in_carry = 1'b0; in_sum = 8'hFF;
        step();
        in_valid = 1'b0;
        chk("run3_valid", 32'(out_valid), 32'h1);
        chk("run3_acc", 32'(out_acc), 32'h0214);
        chk("run3_cnt", 32'(out_count), 32'h3);
        chk("run3_ovf", 32'(out_overflow), 32'h0);
        out_ready = 1'b1;
        step();
        out_ready = 1'b0;
        chk("run3_drop_valid", 32'(out_valid), 32'h0);
        chk("run3_hold_idle", 32'(out_acc), 32'h0214);

        // fifteen beats of 0x1FF: no wrap at 16 bits, wrap at 10 bits
        start = 1'b1; num_samples = 4'd15;
        step();
        start = 1'b0;
        in_valid = 1'b1; in_carry = 1'b1; in_sum = 8'hFF;
        for (int i = 0; i < 15; i++) step();
        in_valid = 1'b0;
        chk("run15_acc", 32'(out_acc), 32'h1DF1);
        chk("run15_ovf", 32'(out_overflow), 32'h0);
        chk("run15_cnt", 32'(out_count), 32'hF);
        chk("run15_acc10", 32'(out_acc10), 32'h1F1);
        chk("run15_ovf10", 32'(out_overflow10), 32'h1);

        // DONE must hold against stray valid/start while not consumed
        num_samples = 4'd2;
        in_valid = 1'b1;
        for (int i = 0; i < 5; i++) begin
            start = ~start;
            step();
            chk("hold_acc", 32'(out_acc), 32'h1DF1);
            chk("hold_cnt", 32'(out_count), 32'hF);
            chk("hold_in_ready", 32'(in_ready), 32'h0);
            chk("hold_valid", 32'(out_valid), 32'h1);
        end
        start = 1'b0; in_valid = 1'b0; out_ready = 1'b1;
        step();
        out_ready = 1'b0;
        chk("hold_release_valid", 32'(out_valid), 32'h0);
        chk("hold_release_busy", 32'(busy), 32'h0);

        // gaps in in_valid
        start = 1'b1; num_samples = 4'd2;
        step();
        start = 1'b0;
        in_valid = 1'b1; in_carry = 1'b0; in_sum = 8'h01;
        step();
        in_valid = 1'b0; in_sum = 8'h40;
        step(); step();
        chk("gap_cnt_mid", 32'(out_count), 32'h1);
        in_valid = 1'b1; in_sum = 8'h02;
        step();
        in_valid = 1'b0;
        chk("gap_valid", 32'(out_valid), 32'h1);
        chk("gap_cnt", 32'(out_count), 32'h2);
        chk("gap_acc", 32'(out_acc), 32'h3);
        out_ready = 1'b1;
        step();
        out_ready = 1'b0;

        // zero-length run
        start = 1'b1; num_samples = 4'd0;
        step();
        start = 1'b0;
        chk("zero_valid", 32'(out_valid), 32'h1);
        chk("zero_acc", 32'(out_acc), 32'h0);
        chk("zero_cnt", 32'(out_count), 32'h0);
        chk("zero_ovf", 32'(out_overflow), 32'h0);
        out_ready = 1'b1;
        step();
        out_ready = 1'b0;
        in_valid = 1'b1; in_sum = 8'h33;
        step();
        in_valid = 1'b0;
        chk("idle_ignore_acc", 32'(out_acc), 32'h0);
        chk("idle_ignore_cnt", 32'(out_count), 32'h0);

        // reset aborts a run
        start = 1'b1; num_samples = 4'd4;
        step();
        start = 1'b0;
        in_valid = 1'b1; in_sum = 8'h20;
        step();
        in_valid = 1'b0; rst = 1'b1; start = 1'b1;
        step();
        rst = 1'b0; start = 1'b0;
        chk("abort_busy", 32'(busy), 32'h0);
        chk("abort_acc", 32'(out_acc), 32'h0);
        chk("abort_cnt", 32'(out_count), 32'h0);
        for (int i = 0; i < 3; i++) begin
            step();
            chk("abort_no_valid", 32'(out_valid), 32'h0);
        end
        start = 1'b1; num_samples = 4'd1;
        step();
        start = 1'b0;
        in_valid = 1'b1; in_carry = 1'b1; in_sum = 8'h07;
        step();
        in_valid = 1'b0;
        chk("fresh_valid", 32'(out_valid), 32'h1);
        chk("fresh_acc", 32'(out_acc), 32'h107);
        chk("fresh_cnt", 32'(out_count), 32'h1);
        out_ready = 1'b1;
        step();
        out_ready = 1'b0;

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
